// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory arbiter: FSM state and port identifiers.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        PORT_P = 1'b0,
        PORT_D = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_P) ? PORT_D : PORT_P;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between pipeline (P) and debug (D) requesters.
// DMEM_ARB_RR_EN selects round-robin on contention; otherwise P has fixed priority.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic  p_req,
    input  logic  d_req,
    input  port_e last,
    output logic  any_req,
    output port_e winner
);

`ifndef DMEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        any_req = p_req | d_req;
        winner  = PORT_P;
        if (p_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
            winner = other_port(last);
`else
            winner = PORT_P;
`endif
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline and debug ports.
// Contention policy set by DMEM_ARB_RR_EN (round-robin) or fixed P priority when undefined.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    state_e             state_q, state_d;
    port_e              owner_q, owner_d;
    port_e              last_q, last_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               p_rvalid_q, p_rvalid_d;
    logic               d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]  p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

    logic               any_req;
    port_e              winner;
    logic               grant;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    dmem_arb_pick u_pick (
        .p_req   (p_req),
        .d_req   (d_req),
        .last    (last_q),
        .any_req (any_req),
        .winner  (winner)
    );

    // Grants are suppressed while reset is held so no access can leak out.
    always_comb begin
        grant     = rst_n && (state_q == ST_IDLE) && any_req;
        win_we    = (winner == PORT_D) ? d_we    : p_we;
        win_addr  = (winner == PORT_D) ? d_addr  : p_addr;
        win_wdata = (winner == PORT_D) ? d_wdata : p_wdata;

        p_gnt     = grant && (winner == PORT_P);
        d_gnt     = grant && (winner == PORT_D);
        p_stall   = p_req && !p_gnt;

        mem_we    = grant && win_we;
        mem_addr  = grant ? win_addr  : addr_q;
        mem_wdata = grant ? win_wdata : wdata_q;

        p_rvalid  = p_rvalid_q;
        d_rvalid  = d_rvalid_q;
        p_rdata   = p_rdata_q;
        d_rdata   = d_rdata_q;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        p_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        p_rdata_d  = p_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    last_d = winner;
                    if (!win_we) begin
                        owner_d   = winner;
                        lat_cnt_d = LAT_W'(RD_LAT);
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                // Memory output is valid during the last wait cycle; capture it here.
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (owner_q == PORT_D) begin
                        d_rdata_d  = mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        p_rdata_d  = mem_rdata;
                        p_rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_P;
            last_q     <= PORT_D;
            lat_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p_rvalid_q <= p_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            p_rdata_q  <= p_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule
